// File: rtl/alu_sequencer.sv
// Issue-side controller for a combinational ALU: accepts one instruction per
// three cycles, registers ALU operands from an 8-entry register file and writes back the result.
module alu_sequencer #(
    parameter int WIDTH = 32,
    parameter int NREGS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [11:0]      instr,
    input  logic             ld_en,
    input  logic [2:0]       ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic [2:0]       rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [2:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_c_out,
    output logic             done,
    output logic             carry_flag,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       rd_q, rd_d;
    logic [2:0]       opcode_q, opcode_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             c_q, c_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];

    logic             handshake_s;
    logic [2:0]       instr_rd_s;
    logic [2:0]       instr_rs1_s;
    logic [2:0]       instr_rs2_s;
    logic [WIDTH-1:0] rs1_val_s;
    logic [WIDTH-1:0] rs2_val_s;

    assign instr_ready = (state_q == IDLE) && !rst;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == WB);
    assign handshake_s = instr_valid && instr_ready;
    assign instr_rd_s  = instr[8:6];
    assign instr_rs1_s = instr[5:3];
    assign instr_rs2_s = instr[2:0];
    assign rd_data     = regs_q[rd_addr];
    assign alu_opcode  = opcode_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign carry_flag  = carry_q;

    // Operand read with same-cycle load forwarding (loads only happen in IDLE).
    always_comb begin
        rs1_val_s = regs_q[instr_rs1_s];
        rs2_val_s = regs_q[instr_rs2_s];
        if (ld_en && (ld_addr == instr_rs1_s)) begin
            rs1_val_s = ld_data;
        end else begin
            rs1_val_s = regs_q[instr_rs1_s];
        end
        if (ld_en && (ld_addr == instr_rs2_s)) begin
            rs2_val_s = ld_data;
        end else begin
            rs2_val_s = regs_q[instr_rs2_s];
        end
    end

    // Next-state logic for the FSM, operand/result registers and register file.
    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        opcode_d = opcode_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        c_d      = c_q;
        carry_d  = carry_q;
        regs_d   = regs_q;
        case (state_q)
            IDLE: begin
                if (ld_en) begin
                    regs_d[ld_addr] = ld_data;
                end else begin
                    regs_d = regs_q;
                end
                if (handshake_s) begin
                    state_d  = ISSUE;
                    rd_d     = instr_rd_s;
                    opcode_d = instr[11:9];
                    a_d      = rs1_val_s;
                    b_d      = rs2_val_s;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = WB;
                res_d   = alu_result;
                c_d     = alu_c_out;
            end
            WB: begin
                state_d      = IDLE;
                regs_d[rd_q] = res_q;
                carry_d      = c_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rd_q     <= 3'd0;
            opcode_q <= 3'd0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            c_q      <= 1'b0;
            carry_q  <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            rd_q     <= rd_d;
            opcode_q <= opcode_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            c_q      <= c_d;
            carry_q  <= carry_d;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a small behavioural ALU
// (opcode 0: add with carry, opcode 1: bitwise and).
module tb_alu_sequencer;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             instr_valid;
    logic             instr_ready;
    logic [11:0]      instr;
    logic             ld_en;
    logic [2:0]       ld_addr;
    logic [WIDTH-1:0] ld_data;
    logic [2:0]       rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic [2:0]       alu_opcode;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_c_out;
    logic             done;
    logic             carry_flag;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    alu_sequencer #(.WIDTH(WIDTH), .NREGS(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .alu_opcode  (alu_opcode),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .alu_c_out   (alu_c_out),
        .done        (done),
        .carry_flag  (carry_flag),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU driven by the sequencer's registered outputs.
    always_comb begin
        alu_result = '0;
        alu_c_out  = 1'b0;
        case (alu_opcode)
            3'd0:    {alu_c_out, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            3'd1:    alu_result = alu_a & alu_b;
            default: alu_result = '0;
        endcase
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reg(input string tag, input logic [2:0] addr, input logic [31:0] exp);
        rd_addr = addr;
        #1;
        check_eq(tag, rd_data, exp);
    endtask

    task automatic load(input logic [2:0] addr, input logic [31:0] val);
        ld_en   = 1'b1;
        ld_addr = addr;
        ld_data = val;
        tick();
        ld_en   = 1'b0;
    endtask

    function automatic logic [11:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2};
    endfunction

    // Full instruction: handshake, check operands in ISSUE, done in WB, then result and carry.
    task automatic run_instr(input string tag, input logic [11:0] iw,
                             input logic [31:0] exp_a, input logic [31:0] exp_b,
                             input logic [31:0] exp_res, input logic exp_c);
        check_eq({tag, "_ready"}, {31'd0, instr_ready}, 32'd1);
        instr_valid = 1'b1;
        instr       = iw;
        tick();
        instr_valid = 1'b0;
        check_eq({tag, "_a"}, alu_a, exp_a);
        check_eq({tag, "_b"}, alu_b, exp_b);
        check_eq({tag, "_issue_done"}, {31'd0, done}, 32'd0);
        tick();
        check_eq({tag, "_wb_done"}, {31'd0, done}, 32'd1);
        check_eq({tag, "_wb_busy"}, {31'd0, busy}, 32'd1);
        tick();
        check_eq({tag, "_idle_done"}, {31'd0, done}, 32'd0);
        check_reg({tag, "_res"}, iw[8:6], exp_res);
        check_eq({tag, "_carry"}, {31'd0, carry_flag}, {31'd0, exp_c});
    endtask

    initial begin
        int gap;
        rst = 1'b1; instr_valid = 1'b0; instr = 12'd0;
        ld_en = 1'b0; ld_addr = 3'd0; ld_data = 32'd0; rd_addr = 3'd0;

        // 1. Reset
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_eq("rst_ready", {31'd0, instr_ready}, 32'd1);
        check_eq("rst_busy",  {31'd0, busy}, 32'd0);
        check_eq("rst_done",  {31'd0, done}, 32'd0);
        check_eq("rst_a", alu_a, 32'd0);
        check_eq("rst_b", alu_b, 32'd0);
        for (int i = 0; i < 8; i++) begin
            check_reg($sformatf("rst_r%0d", i), i[2:0], 32'd0);
        end

        // 2. Add
        load(3'd1, 32'd5);
        load(3'd2, 32'd7);
        run_instr("add", mk(3'd0, 3'd3, 3'd1, 3'd2), 32'd5, 32'd7, 32'd12, 1'b0);

        // 3. Carry, then AND
        load(3'd1, 32'hFFFF_FFFF);
        load(3'd2, 32'd1);
        run_instr("carry", mk(3'd0, 3'd4, 3'd1, 3'd2), 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
        run_instr("and", mk(3'd1, 3'd5, 3'd1, 3'd2), 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);

        // 4. Back-to-back dependency with instr_valid held
        load(3'd1, 32'd5);
        load(3'd2, 32'd7);
        instr_valid = 1'b1;
        instr       = mk(3'd0, 3'd3, 3'd1, 3'd2);
        tick();
        instr = mk(3'd0, 3'd6, 3'd3, 3'd3);
        gap = 0;
        while (!instr_ready && gap < 10) begin
            tick();
            gap++;
        end
        // Two non-ready cycles (ISSUE, WB) means the next accept is 3 edges after the first.
        check_eq("b2b_gap", gap, 32'd2);
        tick();
        instr_valid = 1'b0;
        check_eq("b2b_a", alu_a, 32'd12);
        check_eq("b2b_b", alu_b, 32'd12);
        tick();
        tick();
        check_reg("b2b_r3", 3'd3, 32'd12);
        check_reg("b2b_r6", 3'd6, 32'd24);

        // 5. Loads ignored while busy; same-cycle IDLE load is forwarded
        instr_valid = 1'b1;
        instr       = mk(3'd1, 3'd0, 3'd1, 3'd2);
        tick();
        instr_valid = 1'b0;
        ld_en = 1'b1; ld_addr = 3'd1; ld_data = 32'd99;
        tick();
        tick();
        ld_en = 1'b0;
        check_reg("busyld_r1", 3'd1, 32'd5);
        check_reg("busyld_r0", 3'd0, 32'd5);
        ld_en = 1'b1; ld_addr = 3'd1; ld_data = 32'd9;
        instr_valid = 1'b1;
        instr       = mk(3'd0, 3'd0, 3'd1, 3'd2);
        tick();
        ld_en = 1'b0;
        instr_valid = 1'b0;
        check_eq("fwd_a", alu_a, 32'd9);
        check_eq("fwd_b", alu_b, 32'd7);
        tick();
        tick();
        check_reg("fwd_r1", 3'd1, 32'd9);
        check_reg("fwd_r0", 3'd0, 32'd16);

        // 6. Reset during WB of an instruction targeting r7 (9 + 0xFFFFFFFF carries)
        load(3'd2, 32'hFFFF_FFFF);
        instr_valid = 1'b1;
        instr       = mk(3'd0, 3'd7, 3'd1, 3'd2);
        tick();
        instr_valid = 1'b0;
        tick();
        check_eq("mid_wb_done", {31'd0, done}, 32'd1);
        rst = 1'b1;
        tick();
        check_eq("mid_done", {31'd0, done}, 32'd0);
        check_eq("mid_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("mid_ready", {31'd0, instr_ready}, 32'd1);
        check_eq("mid_carry", {31'd0, carry_flag}, 32'd0);
        check_eq("mid_a", alu_a, 32'd0);
        check_reg("mid_r7", 3'd7, 32'd0);
        check_reg("mid_r1", 3'd1, 32'd0);
        tick();
        check_eq("mid_idle", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
